// File: rtl/cook_timer.sv
// Countdown MM:SS cook timer: keypad shift-in entry while idle,
// one-second BCD countdown while mag_on, timer_done when 00:00.
//
// Ports:
//   clk, resetn (sync active-low), mag_on, clearn (sync active-low),
//   key_valid, key_digit[3:0] -> min_tens/min_ones/sec_tens/sec_ones[3:0],
//   timer_done.
module cook_timer #(
  parameter int CLKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       mag_on,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
);

  localparam int PW = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic [3:0]    mt_n;
  logic [3:0]    mo_n;
  logic [3:0]    st_n;
  logic [3:0]    so_n;
  logic          done_n;
  logic          key_ok;
  logic          run;

  assign key_ok = key_valid && !mag_on && (key_digit <= 4'd9);
  // timer_done is only low when some digit is nonzero, so
  // gating on it also stops the countdown at 00:00.
  assign run    = mag_on && !timer_done;

  always_comb begin
    mt_n    = min_tens;
    mo_n    = min_ones;
    st_n    = sec_tens;
    so_n    = sec_ones;
    presc_n = presc;
    if (!clearn) begin
      mt_n    = 4'd0;
      mo_n    = 4'd0;
      st_n    = 4'd0;
      so_n    = 4'd0;
      presc_n = '0;
    end else if (key_ok) begin
      mt_n    = min_ones;
      mo_n    = sec_tens;
      st_n    = sec_ones;
      so_n    = key_digit;
      presc_n = '0;
    end else if (run) begin
      if (presc == PMAX) begin
        presc_n = '0;
        // Seconds tens above 5 decrement plainly; only a
        // borrow out of 0 reloads it with 5.
        if (sec_ones != 4'd0) begin
          so_n = sec_ones - 4'd1;
        end else begin
          so_n = 4'd9;
          if (sec_tens != 4'd0) begin
            st_n = sec_tens - 4'd1;
          end else begin
            st_n = 4'd5;
            if (min_ones != 4'd0) begin
              mo_n = min_ones - 4'd1;
            end else begin
              mo_n = 4'd9;
              mt_n = min_tens - 4'd1;
            end
          end
        end
      end else begin
        presc_n = presc + 1'b1;
      end
    end
    done_n = ({mt_n, mo_n, st_n, so_n} == 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      presc      <= '0;
      timer_done <= 1'b1;
    end else begin
      min_tens   <= mt_n;
      min_ones   <= mo_n;
      sec_tens   <= st_n;
      sec_ones   <= so_n;
      presc      <= presc_n;
      timer_done <= done_n;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random stimulus
// checked against a minutes/seconds arithmetic reference model.
module tb_cook_timer;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       mag_on;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;

  int checks = 0;
  int passed = 0;

  // reference: minutes 0..99, seconds 0..99, prescaler count
  int m_min = 0;
  int m_sec = 0;
  int m_pc  = 0;

  cook_timer #(.CLKS_PER_SEC(CPS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mag_on    (mag_on),
    .clearn    (clearn),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] shown();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] model_bcd();
    logic [15:0] r;
    r[15:12] = 4'(m_min / 10);
    r[11:8]  = 4'(m_min % 10);
    r[7:4]   = 4'(m_sec / 10);
    r[3:0]   = 4'(m_sec % 10);
    return r;
  endfunction

  task automatic model_edge();
    int n;
    bit zero;
    zero = (m_min == 0) && (m_sec == 0);
    if (!resetn || !clearn) begin
      m_min = 0; m_sec = 0; m_pc = 0;
    end else if (key_valid && !mag_on && key_digit <= 9) begin
      n = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
      m_min = n / 100;
      m_sec = n % 100;
      m_pc  = 0;
    end else if (mag_on && !zero) begin
      if (m_pc == CPS - 1) begin
        m_pc = 0;
        if (m_sec > 0) m_sec--;
        else begin m_min--; m_sec = 59; end
      end else begin
        m_pc++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit kv,
                      input bit mag, input logic [3:0] kd);
    resetn    = ~rst;
    clearn    = ~clr;
    key_valid = kv;
    mag_on    = mag;
    key_digit = kd;
    @(posedge clk);
    model_edge();
    #1;
    chk("digits", 32'(shown()), 32'(model_bcd()));
    chk("done", 32'(timer_done),
        32'((m_min == 0 && m_sec == 0) ? 1 : 0));
  endtask

  task automatic key(input logic [3:0] d);
    step(0, 0, 1, 0, d);
  endtask

  task automatic run(input int n, input bit mag);
    for (int i = 0; i < n; i++) step(0, 0, 0, mag, 4'd0);
  endtask

  task automatic load4(input int a, input int b, input int c,
                       input int d);
    step(0, 1, 0, 0, 4'd0);
    key(4'(a)); key(4'(b)); key(4'(c)); key(4'(d));
  endtask

  initial begin
    resetn = 1'b0; clearn = 1'b1; key_valid = 1'b0;
    mag_on = 1'b0; key_digit = 4'd0;
    #2;
    step(1, 0, 0, 0, 4'd0);
    chk("rst_digits", 32'(shown()), 32'h0000);
    chk("rst_done", 32'(timer_done), 32'd1);

    key(4'd1);
    chk("key1", 32'(shown()), 32'h0001);
    chk("key1_done", 32'(timer_done), 32'd0);
    key(4'd3);
    key(4'd12);
    chk("key12_ign", 32'(shown()), 32'h0013);
    key(4'd0);
    chk("key130", 32'(shown()), 32'h0130);

    load4(0, 0, 1, 0);
    run(4, 1);
    chk("run_4", 32'(shown()), 32'h0009);
    run(36, 1);
    chk("run_40", 32'(shown()), 32'h0000);
    chk("run_40_done", 32'(timer_done), 32'd1);
    run(8, 1);
    chk("hold_zero", 32'(shown()), 32'h0000);

    load4(1, 0, 0, 0); run(4, 1);
    chk("b_1000", 32'(shown()), 32'h0959);
    load4(0, 1, 0, 0); run(4, 1);
    chk("b_0100", 32'(shown()), 32'h0059);
    load4(0, 0, 9, 0); run(4, 1);
    chk("b_0090", 32'(shown()), 32'h0089);
    load4(0, 0, 6, 0); run(4, 1);
    chk("b_0060", 32'(shown()), 32'h0059);

    load4(0, 0, 0, 5);
    run(2, 1); run(10, 0);
    chk("pause", 32'(shown()), 32'h0005);
    run(1, 1);
    chk("resume1", 32'(shown()), 32'h0005);
    run(1, 1);
    chk("resume2", 32'(shown()), 32'h0004);

    load4(0, 2, 0, 0);
    run(2, 1);
    step(0, 0, 1, 1, 4'd7);
    step(0, 0, 1, 1, 4'd3);
    chk("key_mag", 32'(shown()), 32'h0159);
    step(0, 1, 0, 1, 4'd0);
    chk("clr", 32'(shown()), 32'h0000);
    chk("clr_done", 32'(timer_done), 32'd1);

    load4(9, 9, 9, 9);
    chk("max", 32'(shown()), 32'h9999);
    step(1, 0, 0, 1, 4'd0);
    chk("rst_any", 32'(shown()), 32'h0000);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) == 0, $urandom_range(79) == 0,
           $urandom_range(4) == 0, $urandom_range(9) < 6,
           4'($urandom_range(15)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
